vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Pixel-domain decoder that consumes the free-running horizontal and vertical counts produced by the wrap-around counters and turns them into VGA sync, blanking and pixel-coordinate signals. It issues pixel coordinates one cycle after the counts, then delays sync/blank by a programmable pipeline depth so they line up with pixel data returning from the frame-buffer lookup. It also checks the counter sequence and flags any skip, stall or out-of-range value.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths (H_TOTAL = sum = 800)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths (V_TOTAL = 525)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 2, extra cycles (1..4) applied to sync/blank/strobe outputs

Ports:
- ticks  in  1  pixel clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- h_count  in  32  horizontal count, 0..H_TOTAL-1
- v_count  in  32  vertical count, 0..V_TOTAL-1
- err_clr  in  1  synchronous clear of count_err
- pixel_x  out  10  visible column, 0 when blanked (stage 0)
- pixel_y  out  10  visible row, 0 when blanked (stage 0)
- fetch_en  out  1  stage-0 visible flag, frame-buffer read request
- hsync  out  1  horizontal sync (delayed)
- vsync  out  1  vertical sync (delayed)
- video_on  out  1  visible-area enable (delayed)
- line_start  out  1  one-cycle pulse at h=0 of each visible line (delayed)
- frame_start  out  1  one-cycle pulse at h=0,v=0 (delayed)
- count_err  out  1  sticky counter-sequence error

## Operation
- Decode per sample: visible = h<H_VISIBLE && v<V_VISIBLE; hs_act = h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751); vs_act = v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491).
- hsync = hs_act ? SYNC_POL : ~SYNC_POL; same for vsync.
- pixel_x/pixel_y = low 10 bits of h/v when visible, else 0.
- line_start when h==0 && v<V_VISIBLE; frame_start when h==0 && v==0.
- Sequence checker holds previous (h,v) plus a valid flag. Expected next h = prev_h==H_TOTAL-1 ? 0 : prev_h+1. Expected v: if the new h==0, prev_v==V_TOTAL-1 ? 0 : prev_v+1; otherwise v is unchanged.
- count_err is set on a mismatch, or when h≥H_TOTAL or v≥V_TOTAL. The first sample after reset is not compared; it only loads the valid flag. A range violation is flagged even on that first sample.
- count_err is sticky. err_clr clears it. If err_clr and a new error occur in the same cycle, set wins.
- While count_err=1: video_on and fetch_en forced 0; syncs and strobes are still decoded normally.
- Out-of-range h or v: visible=0, no sync active, no strobes.

## Timing
- Stage 0 (pixel_x, pixel_y, fetch_en) is registered: valid 1 cycle after h/v are sampled.
- hsync, vsync, video_on, line_start and frame_start are valid 1+PIPE_DELAY cycles after sampling (default 3).
- count_err asserts 1 cycle after the offending sample.
- Reset (async assert, synchronous deassert handled upstream) sets:
  - hsync and vsync to ~SYNC_POL
  - video_on, fetch_en, line_start, frame_start, count_err to 0
  - pixel_x, pixel_y to 0
  - all delay-line stages to their blanked/inactive values
  - the checker valid flag to 0
- Reset mid-frame: outputs go inactive immediately. After release, the first sample re-arms the checker without flagging an error.

## Structure
- Package vga_timing_pkg holds the default 640x480@60 timing constants, derived H_TOTAL/V_TOTAL, and the sync-window bounds, so the counters' max_value and this block share one source.
- Sub-module sig_delay_line: parameterised width/depth shift register with a per-bit reset value. Instantiated once for the 5-bit bundle {hsync, vsync, video_on, line_start, frame_start}.

## Test plan
- Drive counters through a full frame (800x525) with defaults -> hsync low for exactly 96 cycles per line starting at h=656; vsync low for 2 lines (490, 491); video_on high for 640x480 samples; no count_err.
- Sample h=0,v=0 at cycle N -> pixel_x=0 and fetch_en=1 at N+1; frame_start=1 for one cycle at N+3; line_start=1 at N+3.
- Skip h from 100 to 102 -> count_err=1 one cycle later; video_on=0 while set; err_clr -> count_err=0 next cycle.
- Feed h=800 as the first sample after reset -> count_err=1; feed a non-sequential first sample h=5 -> count_err stays 0.
- Assert reset at h=700 (inside hsync) -> hsync=1 and video_on=0 immediately; resume at h=0,v=0 -> normal outputs after 3 cycles.
- PIPE_DELAY=4, SYNC_POL=1 -> hsync high during 656..751, appearing 5 cycles after sampling.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and sync bundle type
package vga_timing_pkg;

    // Default horizontal timing (pixels)
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    // Default vertical timing (lines)
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Sync windows, inclusive bounds
    localparam int DEF_HS_START  = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HS_END    = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int DEF_VS_START  = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VS_END    = DEF_VS_START + DEF_V_SYNC - 1;

    // Signals that travel together through the output delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
        logic line_start;
        logic frame_start;
    } sync_bundle_t;

    // Inclusive window test on a 32-bit count
    function automatic logic in_window(input logic [31:0] val, input int lo, input int hi);
        return (val >= 32'(lo)) && (val <= 32'(hi));
    endfunction

endpackage

// File: rtl/sig_delay_line.sv
// rtl/sig_delay_line.sv - fixed-depth shift register with per-bit reset value
module sig_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the input through DEPTH register stages
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA sync/blank/coordinate decoder with counter sequence checker
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 2
) (
    input  logic        ticks,
    input  logic        reset,
    input  logic [31:0] h_count,
    input  logic [31:0] v_count,
    input  logic        err_clr,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        fetch_en,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic        count_err
);

    localparam logic [31:0] H_TOTAL  = 32'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [31:0] V_TOTAL  = 32'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam int          HS_START = H_VISIBLE + H_FRONT;
    localparam int          HS_END   = HS_START + H_SYNC - 1;
    localparam int          VS_START = V_VISIBLE + V_FRONT;
    localparam int          VS_END   = VS_START + V_SYNC - 1;
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    localparam sync_bundle_t BUNDLE_IDLE = sync_bundle_t'({~SYNC_ACT, ~SYNC_ACT, 3'b000});

    // Combinational decode of the current sample
    logic         in_range;
    logic         visible;
    sync_bundle_t bundle_d;

    always_comb begin
        in_range = (h_count < H_TOTAL) && (v_count < V_TOTAL);
        visible  = in_range && (h_count < 32'(H_VISIBLE)) && (v_count < 32'(V_VISIBLE));

        bundle_d             = BUNDLE_IDLE;
        bundle_d.video_on    = visible;
        if (in_range) begin
            bundle_d.hsync       = in_window(h_count, HS_START, HS_END) ? SYNC_ACT : ~SYNC_ACT;
            bundle_d.vsync       = in_window(v_count, VS_START, VS_END) ? SYNC_ACT : ~SYNC_ACT;
            bundle_d.line_start  = (h_count == '0) && (v_count < 32'(V_VISIBLE));
            bundle_d.frame_start = (h_count == '0) && (v_count == '0);
        end
    end

    // Stage 0: coordinates and fetch request, plus the first stage of the sync bundle
    logic [9:0]   pixel_x_q;
    logic [9:0]   pixel_y_q;
    logic         fetch_en_q;
    sync_bundle_t bundle_q;

    always_ff @(posedge ticks or negedge reset) begin
        if (!reset) begin
            pixel_x_q  <= '0;
            pixel_y_q  <= '0;
            fetch_en_q <= 1'b0;
            bundle_q   <= BUNDLE_IDLE;
        end else begin
            pixel_x_q  <= visible ? h_count[9:0] : 10'd0;
            pixel_y_q  <= visible ? v_count[9:0] : 10'd0;
            fetch_en_q <= visible;
            bundle_q   <= bundle_d;
        end
    end

    // Align sync/blank/strobes with pixel data returning from the frame buffer
    sync_bundle_t bundle_dly;

    sig_delay_line #(
        .WIDTH   (5),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (BUNDLE_IDLE)
    ) u_sync_dly (
        .clk_i  (ticks),
        .rst_ni (reset),
        .d_i    (bundle_q),
        .q_o    (bundle_dly)
    );

    // Sequence checker: expected successor of the previous sample
    logic        chk_valid_q;
    logic [31:0] prev_h_q;
    logic [31:0] prev_v_q;
    logic        err_q;
    logic [31:0] exp_h;
    logic [31:0] exp_v;
    logic        new_err;
    logic        err_d;

    always_comb begin
        exp_h = (prev_h_q == H_TOTAL - 32'd1) ? 32'd0 : prev_h_q + 32'd1;
        exp_v = prev_v_q;
        if (h_count == '0) begin
            exp_v = (prev_v_q == V_TOTAL - 32'd1) ? 32'd0 : prev_v_q + 32'd1;
        end
        new_err = !in_range || (chk_valid_q && ((h_count != exp_h) || (v_count != exp_v)));
        // A fresh error outranks a simultaneous clear
        err_d = new_err ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    // Checker state: first sample after reset only arms the comparison
    always_ff @(posedge ticks or negedge reset) begin
        if (!reset) begin
            chk_valid_q <= 1'b0;
            prev_h_q    <= '0;
            prev_v_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            chk_valid_q <= 1'b1;
            prev_h_q    <= h_count;
            prev_v_q    <= v_count;
            err_q       <= err_d;
        end
    end

    // Suppress drawing while the counters are untrusted; syncs keep running
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign fetch_en    = fetch_en_q && !err_q;
    assign hsync       = bundle_dly.hsync;
    assign vsync       = bundle_dly.vsync;
    assign video_on    = bundle_dly.video_on && !err_q;
    assign line_start  = bundle_dly.line_start;
    assign frame_start = bundle_dly.frame_start;
    assign count_err   = err_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    logic        ticks;
    logic        reset;
    logic [31:0] h_count;
    logic [31:0] v_count;
    logic        err_clr;

    logic [9:0]  a_px, a_py, b_px, b_py;
    logic        a_fe, a_hs, a_vs, a_von, a_ls, a_fs, a_err;
    logic        b_fe, b_hs, b_vs, b_von, b_ls, b_fs, b_err;

    int n_vec = 0;
    int n_bad = 0;

    // Applied-sample history, index 0 = most recently applied
    logic [31:0] hh [8];
    logic [31:0] vv [8];
    logic        hv [8];

    vga_sync_gen u_dut_a (
        .ticks(ticks), .reset(reset), .h_count(h_count), .v_count(v_count), .err_clr(err_clr),
        .pixel_x(a_px), .pixel_y(a_py), .fetch_en(a_fe), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_von), .line_start(a_ls), .frame_start(a_fs), .count_err(a_err)
    );

    vga_sync_gen #(.SYNC_POL(1), .PIPE_DELAY(4)) u_dut_b (
        .ticks(ticks), .reset(reset), .h_count(h_count), .v_count(v_count), .err_clr(err_clr),
        .pixel_x(b_px), .pixel_y(b_py), .fetch_en(b_fe), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_von), .line_start(b_ls), .frame_start(b_fs), .count_err(b_err)
    );

    initial begin
        ticks = 1'b0;
        forever #5 ticks = ~ticks;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {hsync, vsync, video_on, line_start, frame_start} for one sample, 640x480 hand values
    function automatic logic [4:0] exp_bundle(input logic ok, input logic [31:0] h,
                                               input logic [31:0] v, input logic pol);
        logic hs, vs;
        if (!ok || h >= 32'd800 || v >= 32'd525) return {~pol, ~pol, 3'b000};
        hs = (h >= 32'd656 && h <= 32'd751) ? pol : ~pol;
        vs = (v == 32'd490 || v == 32'd491) ? pol : ~pol;
        return {hs, vs, (h < 32'd640 && v < 32'd480), (h == 0 && v < 32'd480), (h == 0 && v == 0)};
    endfunction

    function automatic logic [20:0] exp_s0(input logic ok, input logic [31:0] h, input logic [31:0] v);
        if (ok && h < 32'd640 && v < 32'd480) return {h[9:0], v[9:0], 1'b1};
        return 21'd0;
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < 8; i++) begin
            hh[i] = '0;
            vv[i] = '0;
            hv[i] = 1'b0;
        end
    endtask

    // One pixel cycle: optionally check outputs against history, then apply the next sample
    task automatic cyc(input logic [31:0] h, input logic [31:0] v, input logic clr, input logic model);
        logic [4:0] ea, eb;
        @(negedge ticks);
        if (model) begin
            ea = exp_bundle(hv[2], hh[2], vv[2], 1'b0);
            eb = exp_bundle(hv[4], hh[4], vv[4], 1'b1);
            chk("a_stage0", {11'd0, a_px, a_py, a_fe}, {11'd0, exp_s0(hv[0], hh[0], vv[0])});
            chk("b_stage0", {11'd0, b_px, b_py, b_fe}, {11'd0, exp_s0(hv[0], hh[0], vv[0])});
            chk("a_bundle", {27'd0, a_hs, a_vs, a_von, a_ls, a_fs}, {27'd0, ea});
            chk("b_bundle", {27'd0, b_hs, b_vs, b_von, b_ls, b_fs}, {27'd0, eb});
            chk("no_err", {30'd0, a_err, b_err}, 32'd0);
        end
        h_count = h;
        v_count = v;
        err_clr = clr;
        reset   = 1'b1;
        for (int i = 7; i > 0; i--) begin
            hh[i] = hh[i-1];
            vv[i] = vv[i-1];
            hv[i] = hv[i-1];
        end
        hh[0] = h;
        vv[0] = v;
        hv[0] = 1'b1;
    endtask

    // Stream n sequential samples starting at (h0, v0) with the model checking every cycle
    task automatic run(input logic [31:0] h0, input logic [31:0] v0, input int n);
        logic [31:0] h, v;
        h = h0;
        v = v0;
        for (int i = 0; i < n; i++) begin
            cyc(h, v, 1'b0, 1'b1);
            if (h == 32'(DEF_H_TOTAL - 1)) begin
                h = 0;
                v = (v == 32'(DEF_V_TOTAL - 1)) ? 32'd0 : v + 32'd1;
            end else begin
                h = h + 32'd1;
            end
        end
    endtask

    // Hold reset over two edges; the next cyc call releases it together with its sample
    task automatic rst();
        @(negedge ticks);
        reset   = 1'b0;
        err_clr = 1'b0;
        clear_hist();
        @(negedge ticks);
    endtask

    initial begin
        reset   = 1'b0;
        h_count = '0;
        v_count = '0;
        err_clr = 1'b0;
        clear_hist();

        // Reset state
        @(negedge ticks);
        chk("rst_a_bundle", {27'd0, a_hs, a_vs, a_von, a_ls, a_fs}, 32'b11000);
        chk("rst_b_bundle", {27'd0, b_hs, b_vs, b_von, b_ls, b_fs}, 32'b00000);
        chk("rst_stage0", {11'd0, a_px, a_py, a_fe}, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);

        // Frame start latency: stage 0 one cycle, strobes three cycles
        cyc(0, 0, 1'b0, 1'b1);
        cyc(1, 0, 1'b0, 1'b1);
        chk("fs_fetch_n1", {31'd0, a_fe}, 32'd1);
        chk("fs_px_n1", {22'd0, a_px}, 32'd0);
        chk("fs_strobe_n1", {30'd0, a_fs, a_ls}, 32'd0);
        cyc(2, 0, 1'b0, 1'b1);
        chk("fs_strobe_n2", {30'd0, a_fs, a_ls}, 32'd0);
        cyc(3, 0, 1'b0, 1'b1);
        chk("fs_strobe_n3", {30'd0, a_fs, a_ls}, 32'b11);
        cyc(4, 0, 1'b0, 1'b1);
        chk("fs_strobe_n4", {30'd0, a_fs, a_ls}, 32'd0);
        chk("fs_px_n4", {22'd0, a_px}, 32'd3);
        run(5, 0, 1595);

        // Visible/blank boundary and vertical sync lines
        rst();
        run(0, 478, 15 * 800);

        // Vertical wrap into the next frame
        rst();
        run(0, 523, 3 * 800);

        // Skip 100 -> 102, sticky error, masking, clear, set-wins
        rst();
        cyc(98, 0, 1'b0, 1'b0);
        cyc(99, 0, 1'b0, 1'b0);
        cyc(100, 0, 1'b0, 1'b0);
        cyc(102, 0, 1'b0, 1'b0);
        cyc(103, 0, 1'b0, 1'b0);
        chk("skip_err", {31'd0, a_err}, 32'd1);
        chk("skip_fetch_masked", {31'd0, a_fe}, 32'd0);
        cyc(104, 0, 1'b0, 1'b0);
        chk("skip_err_sticky", {31'd0, a_err}, 32'd1);
        chk("skip_von_masked", {31'd0, a_von}, 32'd0);
        chk("skip_px_still_decoded", {22'd0, a_px}, 32'd103);
        cyc(105, 0, 1'b1, 1'b0);
        cyc(106, 0, 1'b0, 1'b0);
        chk("clr_err", {31'd0, a_err}, 32'd0);
        chk("clr_fetch", {31'd0, a_fe}, 32'd1);
        cyc(110, 0, 1'b1, 1'b0);
        cyc(111, 0, 1'b0, 1'b0);
        chk("set_wins", {31'd0, a_err}, 32'd1);

        // Range violation on the very first sample
        rst();
        cyc(800, 0, 1'b0, 1'b0);
        cyc(0, 0, 1'b0, 1'b0);
        chk("range_first", {31'd0, a_err}, 32'd1);
        chk("range_no_fetch", {31'd0, a_fe}, 32'd0);

        // Non-sequential first sample only arms the checker
        rst();
        cyc(5, 0, 1'b0, 1'b0);
        cyc(6, 0, 1'b0, 1'b0);
        chk("first_arm", {31'd0, a_err}, 32'd0);
        cyc(7, 0, 1'b0, 1'b0);
        chk("first_arm_n2", {31'd0, a_err}, 32'd0);
        chk("first_arm_px", {22'd0, a_px}, 32'd6);

        // Reset inside hsync, then restart at the frame origin
        rst();
        run(690, 0, 11);
        @(negedge ticks);
        chk("mid_hsync_active", {31'd0, a_hs}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_hsync", {31'd0, a_hs}, 32'd1);
        chk("mid_rst_b_hsync", {31'd0, b_hs}, 32'd0);
        chk("mid_rst_von", {30'd0, a_von, a_fe}, 32'd0);
        clear_hist();
        @(negedge ticks);
        run(0, 0, 800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
